// File: rtl/udp_rx_buffer.sv
// Double-banked receive buffer between the UDP parser and the application.
// The write side fills one 256-word bank per frame and commits it on frame_end.
// The read side presents committed banks in commit order for word-by-word readout.
module udp_rx_buffer #(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [31:0]           wr_data,
  input  logic                  wr_valid,
  input  logic                  frame_end,
  input  logic [15:0]           rx_len,
  output logic                  frame_ready,
  output logic [15:0]           frame_len,
  output logic [DEPTH_LOG2:0]   frame_words,
  input  logic                  rd_en,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned UDP_HDR_BYTES = 8;

  typedef enum logic {
    S_IDLE,
    S_PRESENT
  } rd_state_t;

  logic [31:0]           mem [2*DEPTH];
  logic [1:0]            full;
  logic [15:0]           len_q   [2];
  logic [CNT_W-1:0]      words_q [2];

  logic                  wr_bank;
  logic [CNT_W-1:0]      wr_ptr;
  logic                  bad;

  logic                  rd_bank;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  rd_state_t             state, state_next;

  logic                  wr_accept;
  logic                  bad_now;
  logic [CNT_W-1:0]      wr_count;
  logic                  commit;
  logic                  drop;
  logic [15:0]           len_calc;
  logic                  rd_fire;
  logic                  rd_done;

  // Write-side decisions: accept/discard of the current word and frame outcome
  always_comb begin
    wr_accept = wr_valid && !full[wr_bank] && (wr_ptr < CNT_W'(DEPTH));
    bad_now   = bad || (wr_valid && !wr_accept);
    wr_count  = wr_ptr + CNT_W'(wr_accept);
    commit    = frame_end && !bad_now && (wr_count != '0);
    drop      = frame_end && !commit && ((wr_count != '0) || bad_now);
    len_calc  = (rx_len >= 16'(UDP_HDR_BYTES)) ? (rx_len - 16'(UDP_HDR_BYTES)) : 16'd0;
  end

  // Payload storage; no reset, stale words are never presented
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[{wr_bank, wr_ptr[DEPTH_LOG2-1:0]}] <= wr_data;
    end
  end

  // Write pointer, bad flag, per-bank descriptors and saturating counters
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_bank    <= 1'b0;
      wr_ptr     <= '0;
      bad        <= 1'b0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      words_q[0] <= '0;
      words_q[1] <= '0;
    end else begin
      if (frame_end) begin
        wr_ptr <= '0;
        bad    <= 1'b0;
      end else begin
        wr_ptr <= wr_count;
        bad    <= bad_now;
      end
      if (commit) begin
        len_q[wr_bank]   <= len_calc;
        words_q[wr_bank] <= wr_count;
        wr_bank          <= ~wr_bank;
        if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
      end
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Bank occupancy: set by commit on wr_bank, cleared by final readout on rd_bank
  always_ff @(posedge clk) begin
    if (clr) begin
      full <= 2'b00;
    end else begin
      if (commit)  full[wr_bank] <= 1'b1;
      if (rd_done) full[rd_bank] <= 1'b0;
    end
  end

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Read FSM next-state and readout strobes
  always_comb begin
    state_next = state;
    rd_fire    = 1'b0;
    rd_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (full[rd_bank]) state_next = S_PRESENT;
      end
      S_PRESENT: begin
        if (rd_en) begin
          rd_fire = 1'b1;
          if ({1'b0, rd_ptr} == (frame_words - CNT_W'(1))) begin
            rd_done    = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Registered readout outputs, read pointer and bank selection
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_bank     <= 1'b0;
      rd_ptr      <= '0;
      frame_ready <= 1'b0;
      frame_len   <= '0;
      frame_words <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
    end else begin
      frame_ready <= (state_next == S_PRESENT);
      rd_valid    <= rd_fire;
      rd_last     <= rd_done;
      if ((state == S_IDLE) && (state_next == S_PRESENT)) begin
        frame_len   <= len_q[rd_bank];
        frame_words <= words_q[rd_bank];
      end
      if (rd_fire) begin
        rd_data <= mem[{rd_bank, rd_ptr}];
      end
      if (rd_done) begin
        rd_ptr  <= '0;
        rd_bank <= ~rd_bank;
      end else if (rd_fire) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
    end
  end

endmodule

// File: tb/tb_udp_rx_buffer.sv
// Bench for udp_rx_buffer: vector table, directed corner sequences and random
// traffic, all checked against a frame-queue reference model.
module tb_udp_rx_buffer;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        frame_end;
  logic [15:0] rx_len;
  logic        frame_ready;
  logic [15:0] frame_len;
  logic [8:0]  frame_words;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  udp_rx_buffer #(.DEPTH_LOG2(8)) dut (
    .clk(clk), .clr(clr), .wr_data(wr_data), .wr_valid(wr_valid),
    .frame_end(frame_end), .rx_len(rx_len), .frame_ready(frame_ready),
    .frame_len(frame_len), .frame_words(frame_words), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: committed frames as a word stream plus per-frame size/length
  logic [31:0] m_wq[$];
  int          m_fsz[$];
  logic [15:0] m_flen[$];
  logic [31:0] m_cur[$];
  bit          m_bad;
  bit          m_present;
  int          m_rdptr;
  int          m_fcnt;
  int          m_dcnt;
  logic        m_rv;
  logic        m_rl;
  logic [31:0] m_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input logic c, input logic wv, input logic [31:0] wd,
                            input logic fe, input logic [15:0] rl, input logic re);
    bit accept, bad_now, do_pop;
    if (c) begin
      m_wq.delete(); m_fsz.delete(); m_flen.delete(); m_cur.delete();
      m_bad = 0; m_present = 0; m_rdptr = 0; m_fcnt = 0; m_dcnt = 0;
      m_rv = 0; m_rl = 0; m_rd = 0;
      return;
    end
    m_rv = 0; m_rl = 0; do_pop = 0;
    if (m_present) begin
      if (re) begin
        m_rv = 1;
        m_rd = m_wq.pop_front();
        if (m_rdptr == m_fsz[0] - 1) begin
          m_rl = 1; do_pop = 1; m_present = 0; m_rdptr = 0;
        end else begin
          m_rdptr++;
        end
      end
    end else if (m_fsz.size() > 0) begin
      m_present = 1;
    end
    // A free bank exists for writing unless both banks hold committed frames
    accept  = wv && (m_fsz.size() < 2) && (m_cur.size() < 256);
    bad_now = m_bad || (wv && !accept);
    if (accept) m_cur.push_back(wd);
    if (do_pop) begin
      void'(m_fsz.pop_front());
      void'(m_flen.pop_front());
    end
    if (fe) begin
      if (!bad_now && m_cur.size() > 0) begin
        foreach (m_cur[i]) m_wq.push_back(m_cur[i]);
        m_fsz.push_back(m_cur.size());
        m_flen.push_back((rl >= 16'd8) ? rl - 16'd8 : 16'd0);
        if (m_fcnt < 65535) m_fcnt++;
      end else if (m_cur.size() > 0 || bad_now) begin
        if (m_dcnt < 65535) m_dcnt++;
      end
      m_cur.delete();
      m_bad = 0;
    end else begin
      m_bad = bad_now;
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare #1 later
  task automatic step(input logic c, input logic wv, input logic [31:0] wd,
                      input logic fe, input logic [15:0] rl, input logic re);
    clr = c; wr_valid = wv; wr_data = wd; frame_end = fe; rx_len = rl; rd_en = re;
    @(posedge clk);
    model_edge(c, wv, wd, fe, rl, re);
    #1;
    check("frame_ready", 32'(frame_ready), 32'(m_present));
    check("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    check("drop_cnt", 32'(drop_cnt), 32'(m_dcnt));
    check("rd_valid", 32'(rd_valid), 32'(m_rv));
    check("rd_last", 32'(rd_last), 32'(m_rl));
    if (m_rv) check("rd_data", rd_data, m_rd);
    if (m_present) begin
      check("frame_len", 32'(frame_len), 32'(m_flen[0]));
      check("frame_words", 32'(frame_words), 32'(m_fsz[0]));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic read_n(input int n);
    repeat (n) step(1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic send_frame(input int n, input logic [31:0] base, input logic [15:0] rl);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, base + 32'(i), 1'(i == n - 1), rl, 1'b0);
  endtask

  typedef struct {
    logic        wv;
    logic [31:0] wd;
    logic        fe;
    logic [15:0] rl;
    logic        re;
    logic        e_ready;
    logic        e_rv;
    logic [31:0] e_rd;
    logic        e_last;
    logic [15:0] e_fcnt;
    logic [8:0]  e_words;
    logic [15:0] e_len;
  } vec_t;

  vec_t tv[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; wr_valid = 1'b0; wr_data = '0; frame_end = 1'b0; rx_len = '0; rd_en = 1'b0;

    tv[0] = '{1'b1, 32'h11223344, 1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 16'd0, 9'd0, 16'd0};
    tv[1] = '{1'b1, 32'h55667788, 1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 16'd0, 9'd0, 16'd0};
    tv[2] = '{1'b1, 32'h99AA0000, 1'b1, 16'd18, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 16'd1, 9'd0, 16'd0};
    tv[3] = '{1'b0, 32'h0,        1'b0, 16'd0,  1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 16'd1, 9'd3, 16'd10};
    tv[4] = '{1'b0, 32'h0,        1'b0, 16'd0,  1'b1, 1'b1, 1'b1, 32'h11223344, 1'b0, 16'd1, 9'd3, 16'd10};
    tv[5] = '{1'b0, 32'h0,        1'b0, 16'd0,  1'b1, 1'b1, 1'b1, 32'h55667788, 1'b0, 16'd1, 9'd3, 16'd10};
    tv[6] = '{1'b0, 32'h0,        1'b0, 16'd0,  1'b1, 1'b0, 1'b1, 32'h99AA0000, 1'b1, 16'd1, 9'd0, 16'd0};
    tv[7] = '{1'b0, 32'h0,        1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 16'd1, 9'd0, 16'd0};

    // Reset values
    do_reset();
    do_reset();
    check("rst frame_ready", 32'(frame_ready), 32'h0);
    check("rst frame_len", 32'(frame_len), 32'h0);
    check("rst frame_words", 32'(frame_words), 32'h0);
    check("rst rd_data", rd_data, 32'h0);
    check("rst rd_valid", 32'(rd_valid), 32'h0);
    check("rst rd_last", 32'(rd_last), 32'h0);
    check("rst frame_cnt", 32'(frame_cnt), 32'h0);
    check("rst drop_cnt", 32'(drop_cnt), 32'h0);

    // Single frame from the vector table
    for (int i = 0; i < 8; i++) begin
      step(1'b0, tv[i].wv, tv[i].wd, tv[i].fe, tv[i].rl, tv[i].re);
      check($sformatf("tv%0d frame_ready", i), 32'(frame_ready), 32'(tv[i].e_ready));
      check($sformatf("tv%0d rd_valid", i), 32'(rd_valid), 32'(tv[i].e_rv));
      check($sformatf("tv%0d rd_last", i), 32'(rd_last), 32'(tv[i].e_last));
      check($sformatf("tv%0d frame_cnt", i), 32'(frame_cnt), 32'(tv[i].e_fcnt));
      if (tv[i].e_rv) check($sformatf("tv%0d rd_data", i), rd_data, tv[i].e_rd);
      if (tv[i].e_ready) begin
        check($sformatf("tv%0d frame_words", i), 32'(frame_words), 32'(tv[i].e_words));
        check($sformatf("tv%0d frame_len", i), 32'(frame_len), 32'(tv[i].e_len));
      end
    end

    // Ping-pong: two frames committed before any read, read back in order
    do_reset();
    send_frame(2, 32'hA0000000, 16'd16);
    send_frame(4, 32'hB0000000, 16'd40);
    idle(1);
    read_n(8);
    idle(2);
    check("pp frame_cnt", 32'(frame_cnt), 32'd2);
    check("pp frame_ready", 32'(frame_ready), 32'd0);

    // Overflow: third frame with both banks full is dropped
    do_reset();
    send_frame(1, 32'hC1000000, 16'd12);
    send_frame(1, 32'hC2000000, 16'd12);
    send_frame(1, 32'hC3000000, 16'd12);
    check("ovf frame_cnt", 32'(frame_cnt), 32'd2);
    check("ovf drop_cnt", 32'(drop_cnt), 32'd1);
    idle(1);
    read_n(8);
    send_frame(1, 32'hC4000000, 16'd9);
    idle(2);
    check("ovf4 frame_ready", 32'(frame_ready), 32'd1);
    check("ovf4 frame_words", 32'(frame_words), 32'd1);
    check("ovf4 frame_len", 32'(frame_len), 32'd1);
    read_n(1);
    check("ovf4 rd_data", rd_data, 32'hC4000000);

    // Truncation: 257 words drop the frame; a full 256-word frame still fits
    do_reset();
    for (int i = 0; i < 257; i++) step(1'b0, 1'b1, 32'hD0000000 + 32'(i), 1'b0, 16'd0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 16'd1036, 1'b0);
    check("trunc drop_cnt", 32'(drop_cnt), 32'd1);
    check("trunc frame_cnt", 32'(frame_cnt), 32'd0);
    idle(3);
    check("trunc frame_ready", 32'(frame_ready), 32'd0);
    send_frame(256, 32'hE0000000, 16'd1032);
    idle(1);
    check("full256 frame_ready", 32'(frame_ready), 32'd1);
    check("full256 frame_words", 32'(frame_words), 32'd256);
    check("full256 frame_len", 32'(frame_len), 32'd1024);
    read_n(256);
    check("full256 frame_cnt", 32'(frame_cnt), 32'd1);

    // Concurrency: B written and committed while A is read out
    do_reset();
    send_frame(4, 32'hF0000000, 16'd24);
    idle(1);
    check("conc A ready", 32'(frame_ready), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'hF1000000 + 32'(i), 1'(i == 3), 16'd28, 1'b1);
    check("conc gap", 32'(frame_ready), 32'd0);
    idle(1);
    check("conc B ready", 32'(frame_ready), 32'd1);
    check("conc B len", 32'(frame_len), 32'd20);
    check("conc B words", 32'(frame_words), 32'd4);
    read_n(4);
    check("conc B last", rd_data, 32'hF1000003);

    // Reset mid-readout, then an empty frame_end
    do_reset();
    send_frame(4, 32'h77000000, 16'd24);
    idle(1);
    read_n(1);
    do_reset();
    check("mrst frame_ready", 32'(frame_ready), 32'h0);
    check("mrst frame_len", 32'(frame_len), 32'h0);
    check("mrst frame_words", 32'(frame_words), 32'h0);
    check("mrst rd_data", rd_data, 32'h0);
    check("mrst rd_valid", 32'(rd_valid), 32'h0);
    check("mrst frame_cnt", 32'(frame_cnt), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 16'd20, 1'b0);
    check("empty frame_cnt", 32'(frame_cnt), 32'h0);
    check("empty drop_cnt", 32'(drop_cnt), 32'h0);
    idle(3);

    // Random traffic against the model
    do_reset();
    begin
      int rem;
      logic wv, fe, re;
      rem = 3;
      for (int i = 0; i < 3000; i++) begin
        wv = (rem > 0) && ($urandom_range(0, 3) != 0);
        if (wv) rem--;
        fe = (rem == 0) && ($urandom_range(0, 2) == 0);
        if (fe) rem = ($urandom_range(0, 39) == 0) ? int'($urandom_range(250, 260))
                                                   : int'($urandom_range(0, 8));
        re = ($urandom_range(0, 9) < 6) && (((i / 200) % 3) != 2);
        step(1'b0, wv, $urandom, fe, 16'($urandom_range(0, 40)), re);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
